// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: circular prefetch buffer between fetch and decode.
// It holds {pc, inst} pairs and shows the oldest entry to decode without
// waiting for a read cycle. It stalls fetch when full, and a pipeline
// flush empties it. An empty queue presents a NOP (all zeros) to decode.
module inst_fetch_queue #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          if_valid,
    input  logic [31:0]   if_pc,
    input  logic [31:0]   if_inst,
    output logic          if_ready,
    output logic          stall,
    output logic          id_valid,
    output logic [31:0]   id_pc,
    output logic [31:0]   id_inst,
    input  logic          id_ready,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    // Entry storage. It is never cleared: the pointers and count decide what is live.
    logic [63:0]   mem [DEPTH];

    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW:0]   count_reg,  count_next;

    logic          push;
    logic          pop;
    logic [63:0]   head;

    // Handshake status comes only from registered occupancy, so no input feeds through combinationally.
    always_comb begin
        if_ready = (count_reg != FULL_COUNT);
        stall    = (count_reg == FULL_COUNT);
        id_valid = (count_reg != '0);
        count    = count_reg;
    end

    // A flush cancels any transfer in the same cycle, so a discarded push never lands.
    always_comb begin
        push = if_valid & if_ready & ~flush;
        pop  = id_valid & id_ready & ~flush;
    end

    // Next pointer and occupancy values. Flush has priority and restores the empty state.
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + (AW + 1)'(1);
                2'b01:   count_next = count_reg - (AW + 1)'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointer and count registers. Reset clears them at once, without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Store the accepted fetch pair at the write pointer. Pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {if_pc, if_inst};
        end
    end

    // Show-ahead head read, forced to zero (NOP) while the queue is empty.
    always_comb begin
        head    = mem[rd_ptr_reg];
        id_pc   = 32'h0;
        id_inst = 32'h0;
        if (id_valid) begin
            id_pc   = head[63:32];
            id_inst = head[31:0];
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue.
// The stimulus drives directed vectors and queues each entry it expects to be accepted.
// A negedge monitor pops the queue and checks the entry every time decode consumes the head.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          if_valid;
    logic [31:0]   if_pc;
    logic [31:0]   if_inst;
    logic          if_ready;
    logic          stall;
    logic          id_valid;
    logic [31:0]   id_pc;
    logic [31:0]   id_inst;
    logic          id_ready;
    logic [AW:0]   count;

    exp_t exp_q[$];
    int   n_vec;
    int   n_bad;

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .stall    (stall),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_ready (id_ready),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle. When the push should be accepted, queue the expected entry.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic fl, input logic exp_push);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        id_ready = rdy;
        flush    = fl;
        if (fl) exp_q.delete();
        if (exp_push) exp_q.push_back('{pc: pc, inst: inst});
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        id_ready = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: on every consumed head, check it against the oldest expected entry; check for NOP while empty.
    always @(negedge clk) begin
        if (!rst && !flush) begin
            if (id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_pop: got pc %h, required no entry (t=%0t)", id_pc, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pop_pc_inst", {id_pc, id_inst}, {e.pc, e.inst});
                end
            end else if (!id_valid) begin
                check("empty_nop", {id_pc, id_inst}, 64'h0);
            end
        end
    end

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_pc    = 32'h0;
        if_inst  = 32'h0;
        id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_count", 64'(count), 64'd0);
        check("reset_ready_stall", {62'd0, if_ready, stall}, {62'd0, 2'b10});

        // Asynchronous reset in the middle of operation, with no clock edge.
        cycle(1'b1, 32'h100, 32'hAA, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h104, 32'hAB, 1'b0, 1'b0, 1'b1);
        check("pre_reset_count", 64'(count), 64'd2);
        @(negedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_reset_count", 64'(count), 64'd0);
        check("async_reset_flags", {61'd0, id_valid, if_ready, stall}, {61'd0, 3'b010});
        check("async_reset_nop", {id_pc, id_inst}, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill to capacity. The fifth push must be dropped.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'(4 * i), 32'(32'h11 + i), 1'b0, 1'b0, 1'b1);
        check("fill_count", 64'(count), 64'd4);
        check("fill_stall_ready", {62'd0, stall, if_ready}, {62'd0, 2'b10});
        cycle(1'b1, 32'h10, 32'h15, 1'b0, 1'b0, 1'b0);
        check("full_push_ignored", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("drain_count", 64'(count), 64'd0);
        check("drain_id_valid", {63'd0, id_valid}, 64'd0);

        // Streaming: one push and one pop per cycle. Occupancy stays at 1.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'(32'h200 + 4 * i), 32'(32'h1000 + i), 1'b1, 1'b0, 1'b1);
            check("stream_count", 64'(count), 64'd1);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("stream_end_count", 64'(count), 64'd0);

        // Wrap-around: push 3, pop 3, push 4, pop 4.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'(32'h300 + 4 * i), 32'(32'h2000 + i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'(32'h340 + 4 * i), 32'(32'h3000 + i), 1'b0, 1'b0, 1'b1);
        check("wrap_full_count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("wrap_end_count", 64'(count), 64'd0);

        // Flush at count=3, with a push and a pop in the same cycle.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'(32'h400 + 4 * i), 32'(32'h4000 + i), 1'b0, 1'b0, 1'b1);
        check("preflush_count", 64'(count), 64'd3);
        cycle(1'b1, 32'h4FF, 32'hDEAD, 1'b1, 1'b1, 1'b0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_id_valid", {63'd0, id_valid}, 64'd0);
        check("flush_nop", {id_pc, id_inst}, 64'h0);
        cycle(1'b1, 32'h500, 32'h5000, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Full boundary: push and pop together at count=4. The pop wins and the push is dropped.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'(32'h600 + 4 * i), 32'(32'h6000 + i), 1'b0, 1'b0, 1'b1);
        check("boundary_full_stall", {63'd0, stall}, 64'd1);
        cycle(1'b1, 32'h6F0, 32'h60FF, 1'b1, 1'b0, 1'b0);
        check("boundary_count", 64'(count), 64'd3);
        check("boundary_stall_ready", {62'd0, stall, if_ready}, {62'd0, 2'b01});
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("boundary_end_count", 64'(count), 64'd0);

        idle();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction prefetch queue between the fetch stage (PC register plus instruction ROM) and the decode stage. It buffers up to DEPTH fetched {pc, inst} pairs in a circular FIFO and presents the oldest entry to decode in show-ahead form. It raises a stall toward the PC register when full and drops all contents on a pipeline flush (branch or exception redirect). When empty it presents a NOP (all-zero instruction).

## Interface
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset, asynchronous and active-high.
- flush  input  1  discard all queued entries; highest priority.
- if_valid  input  1  fetch stage presents a valid instruction this cycle.
- if_pc  input  32  address of the presented instruction.
- if_inst  input  32  presented instruction word.
- if_ready  output  1  queue can accept a push this cycle; equals (count != DEPTH).
- stall  output  1  stall request to the PC register; equals ~if_ready.
- id_valid  output  1  head entry valid; equals (count != 0).
- id_pc  output  32  head entry pc; 32'h0 when id_valid=0.
- id_inst  output  32  head entry instruction; 32'h0 (NOP) when id_valid=0.
- id_ready  input  1  decode consumes the head entry this cycle.
- count  output  AW+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH x 64-bit entries {pc, inst}. Read pointer rd_ptr and write pointer wr_ptr are AW bits wide and wrap modulo DEPTH. Occupancy is held in the count register.
- push = if_valid & if_ready & ~flush. It writes {if_pc, if_inst} at wr_ptr and increments wr_ptr.
- pop = id_valid & id_ready & ~flush. It increments rd_ptr.
- count update: push only, +1. Pop only, -1. Both, unchanged. Neither, unchanged.
- Full (count == DEPTH): if_ready=0 and stall=1. if_valid is ignored and nothing is written. No same-cycle bypass of a push into a full queue, even when a pop occurs that cycle.
- Empty (count == 0): id_valid=0 and id_pc/id_inst read 0. id_ready is ignored. There is no fall-through: a pushed entry becomes visible the next cycle.
- flush: on the next edge, rd_ptr, wr_ptr and count are cleared to 0. Any push or pop in the flush cycle is discarded. Storage contents need not be cleared.
- Outputs id_* are a combinational read of the head entry, gated by id_valid. if_ready, stall and id_valid are decoded from registered count only, never from same-cycle inputs.

## Timing
- Reset (asynchronous assert, released synchronously by the system): rd_ptr=0, wr_ptr=0, count=0. This gives if_ready=1, stall=0, id_valid=0, id_pc=0 and id_inst=0 immediately on assert, without waiting for clk.
- Reset mid-operation behaves identically to flush but takes effect without a clock edge.
- Latency: push at edge N makes the entry visible at id_* after edge N (cycle N+1) when the queue was empty.
- Throughput: 1 push + 1 pop per cycle sustained when 0 < count < DEPTH.
- Stall timing: stall rises in the cycle after the push that makes count = DEPTH. It falls in the cycle after the first pop from full. The PC register holds its pc while stall=1.
- Wrap-around: after wr_ptr = DEPTH-1 the next push writes entry 0. Ordering is preserved across the wrap.
- Simultaneous flush and rst: rst dominates; both leave the same state.

## Test plan
- Reset: assert rst with no clk edge. Required: count=0, id_valid=0, id_inst=32'h0 and if_ready=1 immediately.
- Fill: id_ready=0, push pc 0x0, 0x4, 0x8, 0xC with inst 0x11..0x14. Required: count=4, stall=1, and a fifth push of pc 0x10 is ignored. Then draining with id_ready=1 yields pc 0x0, 0x4, 0x8, 0xC in order, followed by id_valid=0.
- Streaming: if_valid=1 and id_ready=1 continuously for 10 cycles starting empty. Required: count stays at 1 after the first cycle, and pc increments by 4 every cycle with no gaps.
- Wrap: push 3, pop 3, push 4, pop 4 with DEPTH=4. Required: output order matches push order, and count returns to 0.
- Flush: with count=3, assert flush together with if_valid=1 and id_ready=1. Required: next cycle count=0, id_valid=0 and id_inst=0, and the flush-cycle push never appears.
- Full boundary: at count=4 assert if_valid and id_ready together. Required: count=3 next cycle, if_valid is dropped that cycle, and stall deasserts.
